// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache refill sequencer.
package icache_pkg;

  localparam int IC_ADDR_W     = 16;
  localparam int IC_WORD_W     = 16;
  localparam int IC_LINE_WORDS = 4;
  localparam int LINE_W        = IC_WORD_W * IC_LINE_WORDS;
  localparam int OFFSET_W      = 3;
  localparam int INDEX_W       = 3;
  localparam int TAG_W         = 10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_e;

  function automatic logic [IC_ADDR_W-1:0] line_base(input logic [IC_ADDR_W-1:0] addr);
    return {addr[IC_ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_asm.sv
// Beat counter and line assembly register for one cache-line refill.
module icache_line_asm
  import icache_pkg::*;
#(
  parameter int WORD_W     = IC_WORD_W,
  parameter int LINE_WORDS = IC_LINE_WORDS,
  localparam int BW        = $clog2(LINE_WORDS),
  localparam int LW        = WORD_W * LINE_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              beat_we_i,
  input  logic [WORD_W-1:0] rdata_i,
  output logic [BW-1:0]     beat_o,
  output logic              last_o,
  output logic [LW-1:0]     line_o
);

  logic [BW-1:0] beat_q;
  logic [LW-1:0] line_q;

  // Beat k lands in bits [WORD_W*k +: WORD_W]; the counter wraps after the last beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      line_q <= '0;
    end else if (clr_i) begin
      beat_q <= '0;
      line_q <= '0;
    end else if (beat_we_i) begin
      line_q[beat_q*WORD_W +: WORD_W] <= rdata_i;
      beat_q                          <= beat_q + BW'(1);
    end
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == BW'(LINE_WORDS - 1));
  assign line_o = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for the direct-mapped instruction cache.
// Optional hit/miss counters are built only when ICACHE_PERF_CNT_EN is defined.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = IC_ADDR_W,
  parameter int WORD_W     = IC_WORD_W,
  parameter int LINE_WORDS = IC_LINE_WORDS,
  localparam int LW        = WORD_W * LINE_WORDS,
  localparam int BW        = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_en_i,
  input  logic              hit_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              fill_valid_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [LW-1:0]     fill_data_o,
  output logic [15:0]       hit_count_o,
  output logic [15:0]       miss_count_o
);

  state_e            state_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              fill_valid_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [LW-1:0]     fill_data_q;

  logic              is_run;
  logic              miss;
  logic              stall;
  logic              beat_we;
  logic [BW-1:0]     asm_beat;
  logic              asm_last;
  logic [LW-1:0]     asm_line;
  logic [LW-1:0]     fill_line_d;

  // Miss detect and stall are combinational so the fetch stage freezes in the miss cycle
  always_comb begin
    is_run      = (state_q == RUN);
    miss        = is_run & pend_q & ~hit_i;
    stall       = ~is_run | miss;
    beat_we     = (state_q == REFILL) & mem_ack_i;
    fill_line_d = asm_line;
    fill_line_d[(LINE_WORDS-1)*WORD_W +: WORD_W] = mem_rdata_i;
  end

  icache_line_asm #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_asm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (miss),
    .beat_we_i (beat_we),
    .rdata_i   (mem_rdata_i),
    .beat_o    (asm_beat),
    .last_o    (asm_last),
    .line_o    (asm_line)
  );

  // Sequencer FSM with registered memory and fill outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      line_base_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            pend_q      <= fetch_en_i;
            pend_addr_q <= fetch_addr_i;
          end
          if (miss) begin
            state_q     <= REFILL;
            line_base_q <= line_base(pend_addr_q);
            mem_req_q   <= 1'b1;
            mem_addr_q  <= line_base(pend_addr_q);
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            if (asm_last) begin
              state_q      <= FILL;
              mem_req_q    <= 1'b0;
              fill_valid_q <= 1'b1;
              fill_addr_q  <= line_base_q;
              // The last beat is still on mem_rdata; merge it so the fill is complete this edge
              fill_data_q  <= fill_line_d;
            end else begin
              mem_addr_q <= line_base_q + ADDR_W'((32'(asm_beat) + 32'd1) * (WORD_W / 8));
            end
          end
        end
        FILL: begin
          fill_valid_q <= 1'b0;
          state_q      <= REPLAY;
        end
        REPLAY: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign stall_o      = stall;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign fill_valid_o = fill_valid_q;
  assign fill_addr_o  = fill_addr_q;
  assign fill_data_o  = fill_data_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating counters; the post-replay re-check counts as an ordinary hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      if (is_run && pend_q && hit_i && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (miss && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = 16'h0000;
  assign miss_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a queue-based scoreboard on beats and fills.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_addr;
  logic        fetch_en;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        fill_valid;
  logic [15:0] fill_addr;
  logic [63:0] fill_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_fill_addr_q[$];
  logic [63:0] exp_fill_data_q[$];
  logic [15:0] mon_addr;
  logic [63:0] mon_data;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fetch_addr_i (fetch_addr),
    .fetch_en_i   (fetch_en),
    .hit_i        (hit),
    .stall_o      (stall),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .fill_valid_o (fill_valid),
    .fill_addr_o  (fill_addr),
    .fill_data_o  (fill_data),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a new fetch (no pending fetch beforehand), then report a miss on it
  task automatic issue_miss(input logic [15:0] addr);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    hit        = 1'b0;
    @(negedge clk);
    chk("issue_no_stall", 64'(stall), 64'(0));
    tick();
    @(negedge clk);
    chk("miss_stall_same_cycle", 64'(stall), 64'(1));
    chk("miss_no_req_yet", 64'(mem_req), 64'(0));
    tick();
  endtask

  // Serve nbeats beats starting at base; beat 1 may be delayed by dly1 cycles
  task automatic refill(input logic [15:0] base, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3, input int nbeats,
                        input int dly1, input bit toggle);
    logic [15:0] w [4];
    logic [15:0] ea;
    int          d;
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < nbeats; k++) exp_addr_q.push_back(16'(base + 16'(2 * k)));
    if (nbeats == 4) begin
      exp_fill_addr_q.push_back(base);
      exp_fill_data_q.push_back({w3, w2, w1, w0});
    end
    for (int k = 0; k < nbeats; k++) begin
      d  = (k == 1) ? dly1 : 0;
      ea = 16'(base + 16'(2 * k));
      for (int c = 0; c <= d; c++) begin
        mem_ack   = (c == d);
        mem_rdata = (c == d) ? w[k] : 16'hDEAD;
        if (toggle) begin
          fetch_en   = ~fetch_en;
          fetch_addr = 16'h7FF0;
        end
        @(negedge clk);
        chk("refill_req_held", 64'(mem_req), 64'(1));
        chk("refill_addr_held", 64'(mem_addr), 64'(ea));
        chk("refill_stall", 64'(stall), 64'(1));
        tick();
      end
    end
    mem_ack = 1'b0;
  endtask

  // FILL cycle then REPLAY cycle; the caller drives the RUN re-check afterwards
  task automatic fill_replay(input logic [15:0] base);
    @(negedge clk);
    chk("fill_stall", 64'(stall), 64'(1));
    chk("fill_strobe", 64'(fill_valid), 64'(1));
    tick();
    @(negedge clk);
    chk("replay_stall", 64'(stall), 64'(1));
    chk("fill_one_cycle", 64'(fill_valid), 64'(0));
    chk("fill_addr_hold", 64'(fill_addr), 64'(base));
    tick();
  endtask

  // Scoreboard monitor: every accepted beat and every fill strobe pops an expectation
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: mem_addr %h accepted with nothing expected", mem_addr);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        chk("beat_addr", 64'(mem_addr), 64'(mon_addr));
      end
    end
    if (fill_valid) begin
      if (exp_fill_addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fill: fill_addr %h data %h with nothing expected", fill_addr, fill_data);
      end else begin
        mon_addr = exp_fill_addr_q.pop_front();
        mon_data = exp_fill_data_q.pop_front();
        chk("fill_addr", 64'(fill_addr), 64'(mon_addr));
        chk("fill_data", fill_data, mon_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hit_addrs [3];
    hit_addrs  = '{16'h0002, 16'h0004, 16'h0040};
    rst        = 1'b1;
    fetch_en   = 1'b0;
    fetch_addr = 16'h0000;
    hit        = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 16'h0000;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_fill_valid", 64'(fill_valid), 64'(0));
    chk("rst_fill_addr", 64'(fill_addr), 64'(0));
    chk("rst_fill_data", fill_data, 64'(0));
    chk("rst_hit_count", 64'(hit_count), 64'(0));
    chk("rst_miss_count", 64'(miss_count), 64'(0));
    rst = 1'b0;
    tick();

    // Back-to-back hits at 0x0000,0x0002,0x0004, then a miss at 0x0040
    fetch_en   = 1'b1;
    fetch_addr = 16'h0000;
    hit        = 1'b0;
    @(negedge clk);
    chk("hits_first_no_stall", 64'(stall), 64'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch_addr = hit_addrs[i];
      hit        = 1'b1;
      @(negedge clk);
      chk("hit_no_stall", 64'(stall), 64'(0));
      chk("hit_no_req", 64'(mem_req), 64'(0));
      tick();
    end
    hit = 1'b0;
    @(negedge clk);
    chk("miss40_stall", 64'(stall), 64'(1));
    chk("miss40_no_req_yet", 64'(mem_req), 64'(0));
    tick();
    refill(16'h0040, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4, 0, 1'b0);
    hit = 1'b1;
    fill_replay(16'h0040);
    fetch_en = 1'b0;
    hit      = 1'b1;
    @(negedge clk);
    chk("resume40_no_stall", 64'(stall), 64'(0));
    tick();
    @(negedge clk);
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_count", 64'(hit_count), 64'(4));
    chk("miss_count", 64'(miss_count), 64'(1));
`else
    chk("hit_count_absent", 64'(hit_count), 64'(0));
    chk("miss_count_absent", 64'(miss_count), 64'(0));
`endif
    hit = 1'b0;

    // Stray ack while idle, then a refill with beat 1 acked three cycles late
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("stray_ack_no_req", 64'(mem_req), 64'(0));
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_no_stall", 64'(stall), 64'(0));
    chk("stray_ack_still_idle", 64'(mem_req), 64'(0));
    tick();
    issue_miss(16'h0088);
    refill(16'h0088, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 4, 3, 1'b0);
    fill_replay(16'h0088);
    fetch_en = 1'b0;
    hit      = 1'b1;
    @(negedge clk);
    chk("resume88_no_stall", 64'(stall), 64'(0));
    tick();
    hit = 1'b0;

    // Miss on word 3 with fetch_en toggling during stall; a repeat miss must refetch the same line
    issue_miss(16'h0046);
    refill(16'h0040, 16'h5551, 16'h5552, 16'h5553, 16'h5554, 4, 0, 1'b1);
    fill_replay(16'h0040);
    fetch_en   = 1'b1;
    fetch_addr = 16'h7FF0;
    hit        = 1'b0;
    @(negedge clk);
    chk("remiss_stall", 64'(stall), 64'(1));
    chk("remiss_no_req_yet", 64'(mem_req), 64'(0));
    tick();
    refill(16'h0040, 16'h6661, 16'h6662, 16'h6663, 16'h6664, 4, 0, 1'b0);
    fill_replay(16'h0040);
    fetch_en = 1'b0;
    hit      = 1'b1;
    @(negedge clk);
    chk("resume46_no_stall", 64'(stall), 64'(0));
    tick();
    hit = 1'b0;

    // Reset after two acks aborts the refill; a later miss starts again from beat 0
    issue_miss(16'h00C0);
    refill(16'h00C0, 16'hC001, 16'hC002, 16'h0000, 16'h0000, 2, 0, 1'b0);
    rst      = 1'b1;
    fetch_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_req", 64'(mem_req), 64'(0));
    chk("abort_no_stall", 64'(stall), 64'(0));
    chk("abort_no_fill", 64'(fill_valid), 64'(0));
    repeat (4) tick();
    issue_miss(16'h00C4);
    refill(16'h00C0, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 4, 0, 1'b0);
    fill_replay(16'h00C0);
    fetch_en = 1'b0;
    hit      = 1'b1;
    @(negedge clk);
    chk("resumeC0_no_stall", 64'(stall), 64'(0));
    tick();
    hit = 1'b0;
    repeat (2) tick();

    chk("beats_outstanding", 64'(exp_addr_q.size()), 64'(0));
    chk("fills_outstanding", 64'(exp_fill_addr_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
